// File: rtl/game_score_reporter.sv
// rtl/game_score_reporter.sv - game score capture FSM with timed update/display report sequence
// Optional feature macro: GUEST_SKIP_UPDATE_EN (guest games skip the update phase).
module game_score_reporter #(
    parameter int UPDATE_CYCLES  = 4,
    parameter int DISPLAY_CYCLES = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startGame,
    input  logic       hit,
    input  logic       gameOver,
    input  logic [2:0] userID,
    input  logic       guestIn,
    output logic [2:0] controlSig,
    output logic       isGuest,
    output logic [2:0] intIDin,
    output logic [3:0] scoreOnes,
    output logic [3:0] scoreTens,
    output logic       busy
);

    localparam int MAX_CYCLES = (UPDATE_CYCLES > DISPLAY_CYCLES) ? UPDATE_CYCLES : DISPLAY_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] UPD_LOAD  = CNT_W'(UPDATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DISP_LOAD = CNT_W'(DISPLAY_CYCLES - 1);

    localparam logic [2:0] CODE_IDLE    = 3'd0;
    localparam logic [2:0] CODE_PLAY    = 3'd2;
    localparam logic [2:0] CODE_UPDATE  = 3'd3;
    localparam logic [2:0] CODE_DISPLAY = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_UPDATE,
        S_DISPLAY
    } state_t;

    state_t           state_q;
    logic [2:0]       ctrl_q;
    logic             busy_q;
    logic [3:0]       ones_q;
    logic [3:0]       tens_q;
    logic [2:0]       id_q;
    logic             guest_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0] ones_d;
    logic [3:0] tens_d;
    logic       skip_update;

`ifdef GUEST_SKIP_UPDATE_EN
    assign skip_update = guest_q;
`else
    assign skip_update = 1'b0;
`endif

    // Two-digit BCD increment that sticks at 99.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (!(ones_q == 4'd9 && tens_q == 4'd9)) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ctrl_q  <= CODE_IDLE;
            busy_q  <= 1'b0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            id_q    <= 3'd0;
            guest_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (startGame) begin
                        state_q <= S_PLAY;
                        ctrl_q  <= CODE_PLAY;
                        id_q    <= userID;
                        guest_q <= guestIn;
                        ones_q  <= 4'd0;
                        tens_q  <= 4'd0;
                    end
                end
                S_PLAY: begin
                    // A hit in the gameOver cycle still lands in the reported score.
                    if (hit) begin
                        ones_q <= ones_d;
                        tens_q <= tens_d;
                    end
                    if (gameOver) begin
                        busy_q <= 1'b1;
                        if (skip_update) begin
                            state_q <= S_DISPLAY;
                            ctrl_q  <= CODE_DISPLAY;
                            cnt_q   <= DISP_LOAD;
                        end else begin
                            state_q <= S_UPDATE;
                            ctrl_q  <= CODE_UPDATE;
                            cnt_q   <= UPD_LOAD;
                        end
                    end
                end
                S_UPDATE: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DISPLAY;
                        ctrl_q  <= CODE_DISPLAY;
                        cnt_q   <= DISP_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DISPLAY: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        ctrl_q  <= CODE_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ctrl_q  <= CODE_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign controlSig = ctrl_q;
    assign busy       = busy_q;
    assign scoreOnes  = ones_q;
    assign scoreTens  = tens_q;
    assign intIDin    = id_q;
    assign isGuest    = guest_q;

endmodule

// File: tb/tb_game_score_reporter.sv
// tb/tb_game_score_reporter.sv - table-driven directed bench for game_score_reporter
module tb_game_score_reporter;

    logic       clk = 1'b0;
    logic       rst;
    logic       startGame;
    logic       hit;
    logic       gameOver;
    logic [2:0] userID;
    logic       guestIn;
    logic [2:0] controlSig;
    logic       isGuest;
    logic [2:0] intIDin;
    logic [3:0] scoreOnes;
    logic [3:0] scoreTens;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    game_score_reporter #(.UPDATE_CYCLES(4), .DISPLAY_CYCLES(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .startGame  (startGame),
        .hit        (hit),
        .gameOver   (gameOver),
        .userID     (userID),
        .guestIn    (guestIn),
        .controlSig (controlSig),
        .isGuest    (isGuest),
        .intIDin    (intIDin),
        .scoreOnes  (scoreOnes),
        .scoreTens  (scoreTens),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sg;
        logic       h;
        logic       go;
        logic [2:0] uid;
        logic       gi;
        logic [2:0] e_ctrl;
        logic [3:0] e_ones;
        logic [3:0] e_tens;
        logic [2:0] e_id;
        logic       e_guest;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (vec %0d): got %0d, expected %0d", name, idx, act, exp);
    endtask

    task automatic add(input logic sg, input logic h, input logic go, input logic [2:0] uid,
                       input logic gi, input logic [2:0] ctrl, input logic [3:0] o, input logic [3:0] t,
                       input logic [2:0] id, input logic g, input logic b);
        vec_t v;
        v.sg = sg; v.h = h; v.go = go; v.uid = uid; v.gi = gi;
        v.e_ctrl = ctrl; v.e_ones = o; v.e_tens = t; v.e_id = id; v.e_guest = g; v.e_busy = b;
        vecs.push_back(v);
    endtask

    // gameOver cycle plus the full report; stray inputs are sprinkled in and must be ignored.
    task automatic game_over(input logic with_hit, input logic [3:0] o, input logic [3:0] t,
                             input logic [2:0] id, input logic g);
        int n_upd;
        logic skip;
`ifdef GUEST_SKIP_UPDATE_EN
        skip = g;
`else
        skip = 1'b0;
`endif
        n_upd = skip ? 0 : 4;
        for (int i = 0; i < n_upd + 12; i++) begin
            add((i == 5), (i == 0) ? with_hit : (i % 3 == 1), (i == 0) || (i == 7), 3'd7, 1'b1,
                (i < n_upd) ? 3'd3 : 3'd4, o, t, id, g, 1'b1);
        end
        add(1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 3'd0, o, t, id, g, 1'b0);
    endtask

    task automatic drive(input logic sg, input logic h, input logic go, input logic [2:0] uid, input logic gi);
        @(negedge clk);
        startGame = sg; hit = h; gameOver = go; userID = uid; guestIn = gi;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst = 1'b0; startGame = 1'b0; hit = 1'b0; gameOver = 1'b0; userID = 3'd0; guestIn = 1'b0;

        // Game 1: id 1, four hits.
        add(1, 0, 0, 3'd1, 0, 3'd2, 4'd0, 4'd0, 3'd1, 0, 0);
        for (int i = 1; i <= 4; i++) add(0, 1, 0, 3'd0, 1, 3'd2, 4'(i), 4'd0, 3'd1, 0, 0);
        game_over(0, 4'd4, 4'd0, 3'd1, 0);
        add(0, 1, 0, 3'd0, 0, 3'd0, 4'd4, 4'd0, 3'd1, 0, 0);
        add(0, 0, 1, 3'd0, 0, 3'd0, 4'd4, 4'd0, 3'd1, 0, 0);

        // Game 2: id 2, fourteen hits; startGame during play is ignored.
        add(1, 0, 0, 3'd2, 0, 3'd2, 4'd0, 4'd0, 3'd2, 0, 0);
        for (int i = 1; i <= 14; i++)
            add((i == 3), 1, 0, 3'd6, 1, 3'd2, 4'(i % 10), 4'(i / 10), 3'd2, 0, 0);
        game_over(0, 4'd4, 4'd1, 3'd2, 0);

        // Game 3: 105 hits saturate at 99.
        add(1, 0, 0, 3'd3, 0, 3'd2, 4'd0, 4'd0, 3'd3, 0, 0);
        for (int i = 1; i <= 105; i++) begin
            k = (i > 99) ? 99 : i;
            add(0, 1, 0, 3'd3, 0, 3'd2, 4'(k % 10), 4'(k / 10), 3'd3, 0, 0);
        end
        game_over(1, 4'd9, 4'd9, 3'd3, 0);

        // Game 4: hit coincident with gameOver at 12 reports 13.
        add(1, 0, 0, 3'd4, 0, 3'd2, 4'd0, 4'd0, 3'd4, 0, 0);
        for (int i = 1; i <= 12; i++) add(0, 1, 0, 3'd4, 0, 3'd2, 4'(i % 10), 4'(i / 10), 3'd4, 0, 0);
        game_over(1, 4'd3, 4'd1, 3'd4, 0);

        // Game 5: guest.
        add(1, 0, 0, 3'd5, 1, 3'd2, 4'd0, 4'd0, 3'd5, 1, 0);
        for (int i = 1; i <= 2; i++) add(0, 1, 0, 3'd5, 0, 3'd2, 4'(i), 4'd0, 3'd5, 1, 0);
        game_over(0, 4'd2, 4'd0, 3'd5, 1);

        #12;
        check("reset_ctrl", -1, {1'b0, controlSig}, 4'd0);
        check("reset_busy", -1, {3'b0, busy}, 4'd0);
        check("reset_ones", -1, scoreOnes, 4'd0);
        check("reset_tens", -1, scoreTens, 4'd0);
        check("reset_id", -1, {1'b0, intIDin}, 4'd0);
        check("reset_guest", -1, {3'b0, isGuest}, 4'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].sg, vecs[i].h, vecs[i].go, vecs[i].uid, vecs[i].gi);
            check("ctrl", i, {1'b0, controlSig}, {1'b0, vecs[i].e_ctrl});
            check("ones", i, scoreOnes, vecs[i].e_ones);
            check("tens", i, scoreTens, vecs[i].e_tens);
            check("id", i, {1'b0, intIDin}, {1'b0, vecs[i].e_id});
            check("guest", i, {3'b0, isGuest}, {3'b0, vecs[i].e_guest});
            check("busy", i, {3'b0, busy}, {3'b0, vecs[i].e_busy});
        end

        // Asynchronous reset in the middle of DISPLAY.
        drive(1, 0, 0, 3'd6, 1);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 3'd0, 0);
        drive(0, 0, 1, 3'd0, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 3'd0, 0);
        check("pre_rst_ctrl", -2, {1'b0, controlSig}, 4'd4);
        check("pre_rst_ones", -2, scoreOnes, 4'd3);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ctrl", -2, {1'b0, controlSig}, 4'd0);
        check("async_rst_busy", -2, {3'b0, busy}, 4'd0);
        check("async_rst_ones", -2, scoreOnes, 4'd0);
        check("async_rst_id", -2, {1'b0, intIDin}, 4'd0);
        check("async_rst_guest", -2, {3'b0, isGuest}, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, (i % 4 == 2), 3'd3, 1);
            check("post_rst_ctrl", i, {1'b0, controlSig}, 4'd0);
            check("post_rst_ones", i, scoreOnes, 4'd0);
            check("post_rst_busy", i, {3'b0, busy}, 4'd0);
        end
        drive(1, 0, 0, 3'd2, 0);
        check("restart_ctrl", -3, {1'b0, controlSig}, 4'd2);
        check("restart_id", -3, {1'b0, intIDin}, 4'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_score_reporter.md
GAME_SCORE_REPORTER -- requirements
Module: game_score_reporter

Interface
REQ-001 Parameter UPDATE_CYCLES, default 4: number of cycles controlSig holds code 3 (update) per report.
REQ-002 Parameter DISPLAY_CYCLES, default 12: number of cycles controlSig holds code 4 (display) per report.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 startGame  input  1  one-cycle pulse; begins a game.
REQ-006 hit  input  1  one-cycle pulse; adds one point while playing.
REQ-007 gameOver  input  1  one-cycle pulse; ends the game and starts the report.
REQ-008 userID  input  3  internal ID of the logged-in player, captured at startGame.
REQ-009 guestIn  input  1  guest flag, captured at startGame.
REQ-010 controlSig  output  3  command to the scoring block: 0 idle, 2 play, 3 update, 4 display.
REQ-011 isGuest  output  1  captured guest flag.
REQ-012 intIDin  output  3  captured player ID.
REQ-013 scoreOnes  output  4  BCD ones digit of the current score.
REQ-014 scoreTens  output  4  BCD tens digit of the current score.
REQ-015 busy  output  1  high in UPDATE and DISPLAY.

Function
REQ-016 The FSM SHALL have states IDLE, PLAY, UPDATE and DISPLAY, driving controlSig 0, 2, 3 and 4 respectively, registered.
REQ-017 IDLE->PLAY on startGame, which SHALL capture userID and guestIn and clear both score digits, all in the same edge.
REQ-018 In PLAY, each hit SHALL increment the score as two-digit BCD (ones 9->0 carries into tens); at 99 the score SHALL saturate and further hits SHALL be ignored.
REQ-019 PLAY->UPDATE on gameOver; hit and gameOver in the same cycle SHALL count the hit first, so the final score includes it.
REQ-020 UPDATE SHALL last exactly UPDATE_CYCLES cycles, then go to DISPLAY; DISPLAY SHALL last exactly DISPLAY_CYCLES cycles, then go to IDLE, with one shared down-counter.
REQ-021 scoreOnes, scoreTens, intIDin and isGuest SHALL hold stable throughout UPDATE and DISPLAY, and in IDLE until the next startGame.
REQ-022 startGame, hit and gameOver SHALL be ignored in UPDATE and DISPLAY; hit and gameOver SHALL be ignored in IDLE; startGame SHALL be ignored in PLAY.
REQ-023 Output changes SHALL appear one cycle after the causing input edge; there SHALL be no combinational input-to-output path.

Reset
REQ-024 rst low SHALL asynchronously force IDLE, controlSig=0, scoreOnes=0, scoreTens=0, intIDin=0, isGuest=0, busy=0, and clear the counter.
REQ-025 Reset asserted mid-UPDATE or mid-DISPLAY SHALL abort the report with no further code 3/4 emitted; after release the FSM SHALL wait in IDLE for startGame.

Configuration
REQ-026 Macro GUEST_SKIP_UPDATE_EN: when defined, a game with captured isGuest=1 SHALL go PLAY->DISPLAY directly, with no code-3 cycles; when undefined, guests follow the same PLAY->UPDATE->DISPLAY sequence as registered players.

Verification
REQ-027 Reset, then startGame with userID=1 and guestIn=0, then 4 hits, then gameOver -> controlSig 2, then 3 for 4 cycles, then 4 for 12 cycles, then 0; score 0/4 and intIDin=1 held throughout.
REQ-028 Second game with userID=2 and 14 hits -> scoreTens=1 and scoreOnes=4 at gameOver; the ones digit wraps 9->0 on hit 10.
REQ-029 Game with 105 hits -> score saturates at 9/9; a hit coincident with gameOver at score 12 -> report carries 13.
REQ-030 rst pulsed low during DISPLAY -> immediate controlSig=0 and all outputs 0; hits and gameOver after release -> no effect until startGame.
REQ-031 Guest game with guestIn=1 -> with GUEST_SKIP_UPDATE_EN defined, controlSig goes 2->4 with no 3; without the macro, code 3 appears for 4 cycles.
